// File: rtl/data_mem_responder.sv
// Single-port data memory that answers one load/store at a time with a MemReady pulse.
// Optional extra response delay is compiled in with `define DMEM_WAIT_STATE_EN.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic [1:0]  StoreSize,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        Busy,
    output logic        MisalignErr
);
    localparam int IW = $clog2(DEPTH_WORDS);

    logic [IW+1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_write;
    logic [1:0]    acc_size;
    logic          enter_resp;

`ifdef DMEM_WAIT_STATE_EN
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [IW+1:0] addr_reg;
    logic [31:0]   wdata_reg;
    logic          write_reg;
    logic [1:0]    size_reg;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            write_reg <= 1'b0;
            size_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == IDLE && MemReq) begin
                addr_reg  <= Addr[IW+1:0];
                wdata_reg <= WriteData;
                write_reg <= MemWrite;
                size_reg  <= StoreSize;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        enter_resp = 1'b0;
        case (state_reg)
            IDLE: begin
                if (MemReq) begin
                    if (WAIT_CYCLES > 0) begin
                        state_next = WAIT;
                        cnt_next   = CW'(WAIT_CYCLES - 1);
                    end else begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // In IDLE the access is still on the ports; afterwards it lives in the capture registers.
    assign acc_addr  = (state_reg == IDLE) ? Addr[IW+1:0] : addr_reg;
    assign acc_wdata = (state_reg == IDLE) ? WriteData    : wdata_reg;
    assign acc_write = (state_reg == IDLE) ? MemWrite     : write_reg;
    assign acc_size  = (state_reg == IDLE) ? StoreSize    : size_reg;
`else
    typedef enum logic {IDLE, RESP} state_t;

    state_t state_reg, state_next;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        enter_resp = 1'b0;
        case (state_reg)
            IDLE: begin
                if (MemReq) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign acc_addr  = Addr[IW+1:0];
    assign acc_wdata = WriteData;
    assign acc_write = MemWrite;
    assign acc_size  = StoreSize;
`endif

    logic [31:0]   mem [DEPTH_WORDS];
    logic [IW-1:0] word_idx;
    logic [31:0]   old_word;
    logic [31:0]   lane_data;
    logic [31:0]   merged_word;
    logic [3:0]    byte_en;
    logic          misalign;
    logic          commit;
    logic [31:0]   read_data_reg;
    logic          misalign_reg;
    logic          unused_bits;

    assign word_idx = acc_addr[IW+1:2];
    assign old_word = mem[word_idx];
    assign misalign = (acc_size == 2'b01 && acc_addr[0]) ||
                      (acc_size[1] && acc_addr[1:0] != 2'b00);
    // Gate with Reset so an access sitting on the ports during reset never writes memory.
    assign commit   = enter_resp & Reset;

    always_comb begin
        lane_data = acc_wdata;
        byte_en   = 4'b1111;
        case (acc_size)
            2'b00: begin
                lane_data = {4{acc_wdata[7:0]}};
                byte_en   = 4'b0001 << acc_addr[1:0];
            end
            2'b01: begin
                lane_data = {2{acc_wdata[15:0]}};
                byte_en   = acc_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                lane_data = acc_wdata;
                byte_en   = 4'b1111;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_word[8*gi +: 8] = (acc_write && byte_en[gi]) ? lane_data[8*gi +: 8]
                                                                       : old_word[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (commit && acc_write && !misalign) begin
            mem[word_idx] <= merged_word;
        end
    end

    // Response data is the post-write word for stores, so it is taken from the merge path.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            read_data_reg <= '0;
            misalign_reg  <= 1'b0;
        end else if (enter_resp) begin
            read_data_reg <= misalign ? 32'd0 : merged_word;
            misalign_reg  <= misalign;
        end
    end

    assign MemReady    = (state_reg == RESP);
    assign Busy        = (state_reg != IDLE);
    assign MisalignErr = MemReady & misalign_reg;
    assign ReadData    = read_data_reg;
    assign unused_bits = ^{Addr[31:IW+2], (WAIT_CYCLES != 0)};
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL provide parameter DEPTH_WORDS, default 256: number of 32-bit storage words, power of two.
REQ-002 SHALL provide parameter WAIT_CYCLES, default 2: extra response delay in cycles, used only when DMEM_WAIT_STATE_EN is defined.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port MemReq  input  1  request strobe, sampled only in IDLE.
REQ-006 SHALL provide port MemWrite  input  1  1 = store, 0 = load.
REQ-007 SHALL provide port Addr  input  32  byte address; word index = Addr[log2(DEPTH_WORDS)+1:2], upper bits ignored (wrap).
REQ-008 SHALL provide port WriteData  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 SHALL provide port StoreSize  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-010 SHALL provide port ReadData  output  32  full addressed word, unshifted; sub-word extraction and sign extension are done by the requester.
REQ-011 SHALL provide port MemReady  output  1  one-cycle response pulse.
REQ-012 SHALL provide port Busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL provide port MisalignErr  output  1  pulses with MemReady when the completed access was misaligned.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and RESP, with Busy = (state != IDLE).
REQ-015 In IDLE with MemReq=1, SHALL capture Addr, WriteData, MemWrite and StoreSize, then go to RESP, or to WAIT when the macro is defined and WAIT_CYCLES>0.
REQ-016 In WAIT, SHALL decrement a counter loaded with WAIT_CYCLES-1 and go to RESP in the cycle after it reaches 0.
REQ-017 In RESP, SHALL assert MemReady for exactly one cycle, then return to IDLE unconditionally.
REQ-018 SHALL ignore MemReq whenever Busy=1; no queueing, no error flag.
REQ-019 Latency: request sampled at edge N gives MemReady high during cycle N+1 without the macro, or N+1+WAIT_CYCLES with it.
REQ-020 Maximum throughput is one access per 2 cycles, with the next request accepted in the cycle after MemReady.
REQ-021 Misalignment SHALL be defined as: halfword with Addr[0]=1, or word with Addr[1:0]!=00; a byte access is never misaligned.
REQ-022 An aligned store SHALL update memory on the edge entering RESP, with byte enables selected as follows: byte lane = Addr[1:0]; half lanes = Addr[1] ? [31:16] : [15:0]; word = all lanes.
REQ-023 An aligned load SHALL drive ReadData with the stored word at the captured word index in the MemReady cycle, and hold it until the next response.
REQ-024 A misaligned access SHALL leave memory unchanged, drive ReadData=0 and pulse MisalignErr with MemReady.
REQ-025 A completed store SHALL drive ReadData with the post-write word.
REQ-026 Memory contents SHALL NOT be initialised or cleared by reset.

Reset
REQ-027 While Reset=0, SHALL immediately force state=IDLE, MemReady=0, MisalignErr=0, Busy=0, ReadData=0 and the wait counter to 0.
REQ-028 Reset asserted mid-operation (WAIT or RESP before the write edge) SHALL discard the pending access, including any pending store.
REQ-029 The first request SHALL be accepted on the first rising edge after Reset deasserts.

Configuration
REQ-030 With macro DMEM_WAIT_STATE_EN defined, SHALL implement the WAIT state and counter with latency 1+WAIT_CYCLES; WAIT_CYCLES=0 SHALL behave identically to the macro undefined.
REQ-031 With DMEM_WAIT_STATE_EN undefined, SHALL omit the WAIT state and counter logic, ignore WAIT_CYCLES, and give a fixed latency of 1.

Verification
REQ-032 Word store then load at Addr=0x10, WriteData=0xDEADBEEF -> each MemReady after 1 cycle (macro off); load returns 0xDEADBEEF, MisalignErr=0.
REQ-033 After the word above, byte store 0xAA at Addr=0x12, then half store 0x1234 at Addr=0x10 -> load of 0x10 returns 0xDEAA1234.
REQ-034 Half store at Addr=0x11 -> MisalignErr=1 with MemReady, ReadData=0, word 0x10 unchanged.
REQ-035 Macro on, WAIT_CYCLES=3: request at edge N -> MemReady in cycle N+4; MemReq pulses during Busy are ignored (exactly one MemReady).
REQ-036 Store issued, then Reset=0 during WAIT -> outputs zero immediately; no MemReady; later load of that address returns the old value.
REQ-037 Addr=0x400 with DEPTH_WORDS=256 -> aliases to word 0; store there, load at Addr=0x0 returns the same data.
